// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and physical-memory signals around the cache arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface cache_arbiter_if;
  logic [31:0] icache_arbiter_addr;
  logic        icache_arbiter_read;
  logic [31:0] arbiter_icache_rdata;
  logic        arbiter_icache_resp;

  logic [31:0] dcache_arbiter_addr;
  logic        dcache_arbiter_read;
  logic        dcache_arbiter_write;
  logic [31:0] dcache_arbiter_wdata;
  logic [31:0] arbiter_dcache_rdata;
  logic        arbiter_dcache_resp;

  logic [31:0] arbiter_pmem_addr;
  logic        arbiter_pmem_read;
  logic        arbiter_pmem_write;
  logic [31:0] arbiter_pmem_wdata;
  logic [31:0] pmem_arbiter_rdata;
  logic        pmem_arbiter_resp;

  modport master (
    output icache_arbiter_addr, icache_arbiter_read,
    input  arbiter_icache_rdata, arbiter_icache_resp,
    output dcache_arbiter_addr, dcache_arbiter_read, dcache_arbiter_write, dcache_arbiter_wdata,
    input  arbiter_dcache_rdata, arbiter_dcache_resp,
    input  arbiter_pmem_addr, arbiter_pmem_read, arbiter_pmem_write, arbiter_pmem_wdata,
    output pmem_arbiter_rdata, pmem_arbiter_resp
  );

  modport slave (
    input  icache_arbiter_addr, icache_arbiter_read,
    output arbiter_icache_rdata, arbiter_icache_resp,
    input  dcache_arbiter_addr, dcache_arbiter_read, dcache_arbiter_write, dcache_arbiter_wdata,
    output arbiter_dcache_rdata, arbiter_dcache_resp,
    output arbiter_pmem_addr, arbiter_pmem_read, arbiter_pmem_write, arbiter_pmem_wdata,
    input  pmem_arbiter_rdata, pmem_arbiter_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one memory port between icache (read-only) and dcache (read/write).
// Dcache wins ties, but at most MAX_DSTREAK times in a row while icache waits.
module cache_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DSTREAK);

  state_e      state_r;
  state_e      next_state_s;
  logic [3:0]  streak_r;
  logic [3:0]  streak_next_s;
  logic        d_req_s;
  logic        grant_d_s;
  logic        grant_i_s;
  logic        i_resp_s;
  logic        d_resp_s;
  logic [31:0] pmem_addr_r;
  logic        pmem_read_r;
  logic        pmem_write_r;
  logic [31:0] pmem_wdata_r;

  // Arbitration, next state and streak update.
  always_comb begin
    d_req_s       = bus.dcache_arbiter_read | bus.dcache_arbiter_write;
    grant_d_s     = 1'b0;
    grant_i_s     = 1'b0;
    next_state_s  = state_r;
    streak_next_s = streak_r;
    case (state_r)
      IDLE: begin
        if (d_req_s && (!bus.icache_arbiter_read || (streak_r < MAX_STREAK))) begin
          grant_d_s    = 1'b1;
          next_state_s = SERVE_D;
          // The grant condition already keeps streak below the limit, so +1 saturates.
          if (bus.icache_arbiter_read) begin
            streak_next_s = streak_r + 4'd1;
          end else begin
            streak_next_s = 4'd0;
          end
        end else if (bus.icache_arbiter_read) begin
          grant_i_s     = 1'b1;
          next_state_s  = SERVE_I;
          streak_next_s = 4'd0;
        end else begin
          streak_next_s = 4'd0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_arbiter_resp) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State and streak registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      streak_r <= 4'd0;
    end else begin
      state_r  <= next_state_s;
      streak_r <= streak_next_s;
    end
  end

  // Memory-side registers: captured on grant, strobes cleared on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_addr_r  <= 32'd0;
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
      pmem_wdata_r <= 32'd0;
    end else if (grant_d_s) begin
      pmem_addr_r  <= bus.dcache_arbiter_addr;
      pmem_read_r  <= ~bus.dcache_arbiter_write;
      pmem_write_r <= bus.dcache_arbiter_write;
      pmem_wdata_r <= bus.dcache_arbiter_write ? bus.dcache_arbiter_wdata : 32'd0;
    end else if (grant_i_s) begin
      pmem_addr_r  <= bus.icache_arbiter_addr;
      pmem_read_r  <= 1'b1;
      pmem_write_r <= 1'b0;
      pmem_wdata_r <= 32'd0;
    end else if ((state_r != IDLE) && bus.pmem_arbiter_resp) begin
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end
  end

  // Responses pass straight through to the owner only; nothing leaks while resetting.
  always_comb begin
    i_resp_s = ~rst & (state_r == SERVE_I) & bus.pmem_arbiter_resp;
    d_resp_s = ~rst & (state_r == SERVE_D) & bus.pmem_arbiter_resp;
    bus.arbiter_icache_resp  = i_resp_s;
    bus.arbiter_dcache_resp  = d_resp_s;
    if (i_resp_s) begin
      bus.arbiter_icache_rdata = bus.pmem_arbiter_rdata;
    end else begin
      bus.arbiter_icache_rdata = 32'd0;
    end
    if (d_resp_s) begin
      bus.arbiter_dcache_rdata = bus.pmem_arbiter_rdata;
    end else begin
      bus.arbiter_dcache_rdata = 32'd0;
    end
  end

  assign bus.arbiter_pmem_addr  = pmem_addr_r;
  assign bus.arbiter_pmem_read  = pmem_read_r;
  assign bus.arbiter_pmem_write = pmem_write_r;
  assign bus.arbiter_pmem_wdata = pmem_wdata_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;

  localparam int MAX = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cache_arbiter_if bus ();

  cache_arbiter #(.MAX_DSTREAK(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.icache_arbiter_addr  = 32'd0;
    bus.icache_arbiter_read  = 1'b0;
    bus.dcache_arbiter_addr  = 32'd0;
    bus.dcache_arbiter_read  = 1'b0;
    bus.dcache_arbiter_write = 1'b0;
    bus.dcache_arbiter_wdata = 32'd0;
    bus.pmem_arbiter_rdata   = 32'd0;
    bus.pmem_arbiter_resp    = 1'b0;
  endtask

  task automatic test_reset();
    logic [65:0] pm;
    logic [65:0] rs;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    pm = {bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata};
    rs = {bus.arbiter_icache_resp, bus.arbiter_icache_rdata, bus.arbiter_dcache_resp, bus.arbiter_dcache_rdata};
    n_checks++; if (pm !== 66'd0) begin n_errors++; $display("FAIL reset_pmem got=%h exp=0", pm); end
    n_checks++; if (rs !== 66'd0) begin n_errors++; $display("FAIL reset_resp got=%h exp=0", rs); end
    // dcache write in flight, then reset
    bus.dcache_arbiter_write = 1'b1;
    bus.dcache_arbiter_addr  = 32'h0000_0080;
    bus.dcache_arbiter_wdata = 32'hAAAA_5555;
    tick();
    n_checks++; if (bus.arbiter_pmem_write !== 1'b1) begin n_errors++; $display("FAIL reset_pre_write got=%0b exp=1", bus.arbiter_pmem_write); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dcache_arbiter_write = 1'b0;
    #1;
    pm = {bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata};
    n_checks++; if (pm !== 66'd0) begin n_errors++; $display("FAIL reset_mid_pmem got=%h exp=0", pm); end
    tick();
    bus.pmem_arbiter_resp  = 1'b1;
    bus.pmem_arbiter_rdata = 32'h1111_2222;
    #1;
    rs = {bus.arbiter_icache_resp, bus.arbiter_icache_rdata, bus.arbiter_dcache_resp, bus.arbiter_dcache_rdata};
    n_checks++; if (rs !== 66'd0) begin n_errors++; $display("FAIL reset_late_resp got=%h exp=0", rs); end
    tick();
    bus.pmem_arbiter_resp = 1'b0;
    n_checks++; if ({bus.arbiter_pmem_read, bus.arbiter_pmem_write} !== 2'b00) begin n_errors++; $display("FAIL reset_after_late got=%b exp=00", {bus.arbiter_pmem_read, bus.arbiter_pmem_write}); end
  endtask

  task automatic test_lone_icache();
    bus.icache_arbiter_read = 1'b1;
    bus.icache_arbiter_addr = 32'h0000_1000;
    #1;
    n_checks++; if (bus.arbiter_pmem_read !== 1'b0) begin n_errors++; $display("FAIL ic_not_early got=%0b exp=0", bus.arbiter_pmem_read); end
    tick();
    n_checks++; if ({bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata} !== {32'h0000_1000, 1'b1, 1'b0, 32'd0})
      begin n_errors++; $display("FAIL ic_strobe got=%h/%0b/%0b/%h exp=1000/1/0/0", bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.arbiter_icache_resp !== 1'b0 || bus.arbiter_pmem_read !== 1'b1) begin n_errors++; $display("FAIL ic_wait%0d resp=%0b read=%0b exp resp=0 read=1", i, bus.arbiter_icache_resp, bus.arbiter_pmem_read); end
    end
    tick();
    bus.pmem_arbiter_resp  = 1'b1;
    bus.pmem_arbiter_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if ({bus.arbiter_icache_resp, bus.arbiter_icache_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL ic_resp got=%0b/%h exp=1/deadbeef", bus.arbiter_icache_resp, bus.arbiter_icache_rdata); end
    n_checks++; if ({bus.arbiter_dcache_resp, bus.arbiter_dcache_rdata} !== 33'd0) begin n_errors++; $display("FAIL ic_no_dresp got=%0b/%h exp=0/0", bus.arbiter_dcache_resp, bus.arbiter_dcache_rdata); end
    tick();
    bus.pmem_arbiter_resp   = 1'b0;
    bus.icache_arbiter_read = 1'b0;
    #1;
    n_checks++; if ({bus.arbiter_icache_resp, bus.arbiter_pmem_read} !== 2'b00) begin n_errors++; $display("FAIL ic_done got=%b exp=00", {bus.arbiter_icache_resp, bus.arbiter_pmem_read}); end
    tick();
  endtask

  task automatic test_simultaneous();
    bus.icache_arbiter_read  = 1'b1;
    bus.icache_arbiter_addr  = 32'h0000_0100;
    bus.dcache_arbiter_write = 1'b1;
    bus.dcache_arbiter_addr  = 32'h0000_0200;
    bus.dcache_arbiter_wdata = 32'h1234_5678;
    tick();
    n_checks++; if ({bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata} !== {32'h0000_0200, 1'b0, 1'b1, 32'h1234_5678})
      begin n_errors++; $display("FAIL sim_dfirst got=%h/%0b/%0b/%h exp=200/0/1/12345678", bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata); end
    bus.pmem_arbiter_resp = 1'b1;
    #1;
    n_checks++; if ({bus.arbiter_dcache_resp, bus.arbiter_icache_resp} !== 2'b10) begin n_errors++; $display("FAIL sim_dresp got=%b exp=10", {bus.arbiter_dcache_resp, bus.arbiter_icache_resp}); end
    tick();
    bus.pmem_arbiter_resp    = 1'b0;
    bus.dcache_arbiter_write = 1'b0;
    n_checks++; if ({bus.arbiter_pmem_read, bus.arbiter_pmem_write} !== 2'b00) begin n_errors++; $display("FAIL sim_dead got=%b exp=00", {bus.arbiter_pmem_read, bus.arbiter_pmem_write}); end
    tick();
    n_checks++; if ({bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_wdata} !== {32'h0000_0100, 1'b1, 32'd0}) begin n_errors++; $display("FAIL sim_istrobe got=%h/%0b/%h exp=100/1/0", bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_wdata); end
    bus.pmem_arbiter_resp = 1'b1;
    #1;
    n_checks++; if ({bus.arbiter_dcache_resp, bus.arbiter_icache_resp} !== 2'b01) begin n_errors++; $display("FAIL sim_iresp got=%b exp=01", {bus.arbiter_dcache_resp, bus.arbiter_icache_resp}); end
    tick();
    bus.pmem_arbiter_resp   = 1'b0;
    bus.icache_arbiter_read = 1'b0;
    tick();
  endtask

  task automatic test_stability();
    bus.dcache_arbiter_write = 1'b1;
    bus.dcache_arbiter_addr  = 32'h0000_0200;
    bus.dcache_arbiter_wdata = 32'h0000_0055;
    tick();
    bus.dcache_arbiter_addr  = 32'h0000_0300;
    bus.dcache_arbiter_wdata = 32'h0000_0099;
    bus.dcache_arbiter_read  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({bus.arbiter_pmem_addr, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata} !== {32'h0000_0200, 1'b1, 32'h0000_0055})
        begin n_errors++; $display("FAIL stab_hold%0d got=%h/%0b/%h exp=200/1/55", i, bus.arbiter_pmem_addr, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata); end
      if (i < 2) tick();
    end
    bus.pmem_arbiter_resp = 1'b1;
    #1;
    n_checks++; if (bus.arbiter_dcache_resp !== 1'b1) begin n_errors++; $display("FAIL stab_resp got=%0b exp=1", bus.arbiter_dcache_resp); end
    tick();
    bus.pmem_arbiter_resp    = 1'b0;
    bus.dcache_arbiter_write = 1'b0;
    bus.dcache_arbiter_read  = 1'b0;
    tick();
  endtask

  task automatic test_rw_both();
    bus.dcache_arbiter_read  = 1'b1;
    bus.dcache_arbiter_write = 1'b1;
    bus.dcache_arbiter_addr  = 32'h0000_0040;
    bus.dcache_arbiter_wdata = 32'h0000_0077;
    tick();
    n_checks++; if ({bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata} !== {32'h0000_0040, 1'b0, 1'b1, 32'h0000_0077})
      begin n_errors++; $display("FAIL rw_both got=%h/%0b/%0b/%h exp=40/0/1/77", bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata); end
    bus.pmem_arbiter_resp = 1'b1;
    tick();
    bus.pmem_arbiter_resp    = 1'b0;
    bus.dcache_arbiter_read  = 1'b0;
    bus.dcache_arbiter_write = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic        exp_i;
    logic [31:0] exp_addr;
    bus.icache_arbiter_read = 1'b1;
    bus.icache_arbiter_addr = 32'h1000_0000;
    bus.dcache_arbiter_read = 1'b1;
    bus.dcache_arbiter_addr = 32'h2000_0000;
    for (int n = 0; n <= MAX + 1; n++) begin
      tick();
      exp_i    = (n == MAX);
      exp_addr = exp_i ? 32'h1000_0000 : 32'h2000_0000;
      n_checks++; if ({bus.arbiter_pmem_read, bus.arbiter_pmem_addr} !== {1'b1, exp_addr}) begin n_errors++; $display("FAIL starve_grant%0d got=%0b/%h exp=1/%h", n, bus.arbiter_pmem_read, bus.arbiter_pmem_addr, exp_addr); end
      bus.pmem_arbiter_resp = 1'b1;
      #1;
      n_checks++; if ({bus.arbiter_icache_resp, bus.arbiter_dcache_resp} !== {exp_i, ~exp_i}) begin n_errors++; $display("FAIL starve_resp%0d got=%b exp=%b", n, {bus.arbiter_icache_resp, bus.arbiter_dcache_resp}, {exp_i, ~exp_i}); end
      tick();
      bus.pmem_arbiter_resp = 1'b0;
    end
    bus.icache_arbiter_read = 1'b0;
    bus.dcache_arbiter_read = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          owner;
    int          streak;
    int          mem_wait;
    int          k;
    logic [31:0] m_addr, m_wdata;
    logic        m_rd, m_wr;
    logic        i_done, d_done, ei, ed;
    logic [65:0] exp_pm, got_pm, exp_rs, got_rs;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    owner = 0; streak = 0; mem_wait = 0;
    m_addr = 32'd0; m_wdata = 32'd0; m_rd = 1'b0; m_wr = 1'b0;
    i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.icache_arbiter_read || i_done) begin
        bus.icache_arbiter_read = ($urandom_range(0, 99) < 55);
        bus.icache_arbiter_addr = $urandom;
      end else if (owner == 1 && $urandom_range(0, 3) == 0) begin
        bus.icache_arbiter_addr = $urandom;
      end
      if (!(bus.dcache_arbiter_read || bus.dcache_arbiter_write) || d_done) begin
        k = $urandom_range(0, 3);
        bus.dcache_arbiter_read  = (k == 1 || k == 3);
        bus.dcache_arbiter_write = (k == 2 || k == 3);
        bus.dcache_arbiter_addr  = $urandom;
        bus.dcache_arbiter_wdata = $urandom;
      end else if (owner == 2 && $urandom_range(0, 3) == 0) begin
        bus.dcache_arbiter_addr  = $urandom;
        bus.dcache_arbiter_wdata = $urandom;
      end
      rst = ($urandom_range(0, 149) == 0);
      bus.pmem_arbiter_rdata = $urandom;
      if (rst) begin
        bus.pmem_arbiter_resp = 1'b0;
      end else if (owner != 0) begin
        bus.pmem_arbiter_resp = (mem_wait == 0);
        if (mem_wait > 0) mem_wait--;
      end else begin
        bus.pmem_arbiter_resp = ($urandom_range(0, 7) == 0);
      end
      #1;
      ei = (owner == 1) && bus.pmem_arbiter_resp;
      ed = (owner == 2) && bus.pmem_arbiter_resp;
      exp_rs = {ei, ei ? bus.pmem_arbiter_rdata : 32'd0, ed, ed ? bus.pmem_arbiter_rdata : 32'd0};
      got_rs = {bus.arbiter_icache_resp, bus.arbiter_icache_rdata, bus.arbiter_dcache_resp, bus.arbiter_dcache_rdata};
      n_checks++; if (got_rs !== exp_rs) begin n_errors++; $display("FAIL rand_resp cyc=%0d got=%h exp=%h", c, got_rs, exp_rs); end
      exp_pm = {m_addr, m_rd, m_wr, m_wdata};
      got_pm = {bus.arbiter_pmem_addr, bus.arbiter_pmem_read, bus.arbiter_pmem_write, bus.arbiter_pmem_wdata};
      n_checks++; if (got_pm !== exp_pm) begin n_errors++; $display("FAIL rand_pmem cyc=%0d got=%h exp=%h", c, got_pm, exp_pm); end
      // advance the transaction model
      if (rst) begin
        owner = 0; streak = 0;
        m_addr = 32'd0; m_wdata = 32'd0; m_rd = 1'b0; m_wr = 1'b0;
      end else if (owner == 0) begin
        if ((bus.dcache_arbiter_read || bus.dcache_arbiter_write) && (!bus.icache_arbiter_read || streak < MAX)) begin
          owner   = 2;
          m_addr  = bus.dcache_arbiter_addr;
          m_wr    = bus.dcache_arbiter_write;
          m_rd    = !bus.dcache_arbiter_write;
          m_wdata = bus.dcache_arbiter_write ? bus.dcache_arbiter_wdata : 32'd0;
          streak  = bus.icache_arbiter_read ? ((streak + 1 > MAX) ? MAX : streak + 1) : 0;
          mem_wait = $urandom_range(0, 3);
        end else if (bus.icache_arbiter_read) begin
          owner   = 1;
          m_addr  = bus.icache_arbiter_addr;
          m_rd    = 1'b1;
          m_wr    = 1'b0;
          m_wdata = 32'd0;
          streak  = 0;
          mem_wait = $urandom_range(0, 3);
        end else begin
          streak = 0;
        end
      end else if (bus.pmem_arbiter_resp) begin
        owner = 0;
        m_rd  = 1'b0;
        m_wr  = 1'b0;
      end
      i_done = ei;
      d_done = ed;
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_lone_icache();
    test_simultaneous();
    test_stability();
    test_rw_both();
    test_starvation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
